lpf_out_decimator: RTL and testbench

- Consumes the 38-bit signed output of the ECG low-pass FIR stage (fir_lowpass_parallel_tree).
- Rescales it to 16-bit signed with round-half-up and saturation, then decimates by DECIM.
- Buffers kept samples in a small FIFO and presents them on a valid/ready stream to the downstream ECG feature stage.
- Sits directly after the FIR stage in the sample path.

---
 rtl/lpf_pkg.sv | 21 ++
 rtl/lpf_out_fifo.sv | 57 +++++
 rtl/lpf_out_decimator.sv | 107 ++++++++++
 tb/tb_lpf_out_decimator.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lpf_pkg.sv
// Shared constants and types for the ECG low-pass output path.
package lpf_pkg;

    localparam int unsigned ECG_SAMPLE_W  = 16;
    localparam int unsigned FIR_OUT_W     = 38;
    localparam int unsigned FIR_FRAC_BITS = 15;

    typedef logic signed [ECG_SAMPLE_W-1:0] ecg_sample_t;

    function automatic longint sat_max(input int unsigned w);
        return (longint'(1) <<< (w - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int unsigned w);
        return -(longint'(1) <<< (w - 1));
    endfunction

    localparam longint ECG_SAT_MAX = sat_max(ECG_SAMPLE_W);
    localparam longint ECG_SAT_MIN = sat_min(ECG_SAMPLE_W);

endpackage

// File: rtl/lpf_out_fifo.sv
// Synchronous circular-buffer FIFO with occupancy count; push while full is
// accepted only when a pop happens in the same cycle.
module lpf_out_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       empty,
    output logic                       push_ok
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             full, pop_ok;

    assign empty   = (level_q == '0);
    assign full    = (level_q == LW'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign rdata   = mem_q[rd_ptr_q];
    assign level   = level_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            unique case ({push_ok, pop_ok})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/lpf_out_decimator.sv
// Rescales FIR output to 16-bit with round-half-up and saturation, keeps one
// sample in DECIM, and buffers kept samples on a valid/ready stream.
module lpf_out_decimator
    import lpf_pkg::*;
#(
    parameter int unsigned IN_W  = FIR_OUT_W,
    parameter int unsigned OUT_W = ECG_SAMPLE_W,
    parameter int unsigned SHIFT = FIR_FRAC_BITS,
    parameter int unsigned DECIM = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    input  logic signed [IN_W-1:0]      in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [OUT_W-1:0]     out_data,
    output logic                        sat_pulse,
    output logic                        ovf,
    input  logic                        clr_ovf,
    output logic [$clog2(DEPTH):0]      level
);

    localparam int unsigned RW = IN_W - SHIFT + 1;
    localparam int unsigned PW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [IN_W:0] HALF = {{IN_W{1'b0}}, 1'b1} << (SHIFT - 1);
    localparam longint SAT_HI = sat_max(OUT_W);
    localparam longint SAT_LO = sat_min(OUT_W);

    logic signed [IN_W:0]   sum;
    logic signed [RW-1:0]   rnd;
    logic                   s1_valid_q, s1_keep_q;
    logic signed [RW-1:0]   s1_r_q;
    logic [PW-1:0]          phase_q;
    longint                 r64;
    logic [OUT_W-1:0]       sat_data;
    logic                   clamp, wr_req, pop, push_ok, empty, ovf_q;

    // One extra bit on the sum so adding the half-LSB cannot overflow.
    always_comb begin
        sum = $signed({in_data[IN_W-1], in_data}) + $signed(HALF);
        rnd = RW'(sum >>> SHIFT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_keep_q  <= 1'b0;
            s1_r_q     <= '0;
            phase_q    <= '0;
        end else begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_r_q    <= rnd;
                s1_keep_q <= (phase_q == '0);
                phase_q   <= (phase_q == PW'(DECIM - 1)) ? '0 : phase_q + PW'(1);
            end
        end
    end

    always_comb begin
        r64      = longint'(s1_r_q);
        sat_data = r64[OUT_W-1:0];
        clamp    = 1'b0;
        if (r64 > SAT_HI) begin
            sat_data = SAT_HI[OUT_W-1:0];
            clamp    = 1'b1;
        end else if (r64 < SAT_LO) begin
            sat_data = SAT_LO[OUT_W-1:0];
            clamp    = 1'b1;
        end
    end

    assign wr_req    = s1_valid_q && s1_keep_q;
    assign sat_pulse = wr_req && clamp;
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign ovf       = ovf_q;

    // A drop sets the flag even when a clear is requested in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (wr_req && !push_ok) begin
            ovf_q <= 1'b1;
        end else if (clr_ovf) begin
            ovf_q <= 1'b0;
        end
    end

    lpf_out_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (wr_req),
        .wdata   (sat_data),
        .pop     (pop),
        .rdata   (out_data),
        .level   (level),
        .empty   (empty),
        .push_ok (push_ok)
    );

endmodule

// File: tb/tb_lpf_out_decimator.sv
// Bench for lpf_out_decimator: DECIM=1 and DECIM=4 instances share stimulus;
// vector table, directed corner sequences, and a randomized model comparison.
module tb_lpf_out_decimator;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                in_valid = 1'b0;
    logic                out_ready = 1'b0;
    logic                clr_ovf = 1'b0;
    logic signed [37:0]  in_data = '0;

    logic                ov [2];
    logic signed [15:0]  od [2];
    logic                sp [2];
    logic                of [2];
    logic [2:0]          lv [2];

    int checks = 0;
    int errors = 0;
    int got_q[$];
    int exp_q[$];

    always #5 clk = ~clk;

    lpf_out_decimator #(.DECIM(1), .DEPTH(4)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
        .sat_pulse(sp[0]), .ovf(of[0]), .clr_ovf(clr_ovf), .level(lv[0])
    );

    lpf_out_decimator #(.DECIM(4), .DEPTH(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
        .sat_pulse(sp[1]), .ovf(of[1]), .clr_ovf(clr_ovf), .level(lv[1])
    );

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        clr_ovf = 1'b0;
        #2;
        rst_n = 1'b1;
        step();
    endtask

    task automatic check_got(input string name);
        check({name, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("%s_%0d", name, i), got_q[i], exp_q[i]);
        end
    endtask

    // Feed n samples (start..start+n-1)*2^15 with optional gaps, ready held high,
    // collecting every sample the DECIM=4 instance hands over.
    task automatic run_feed(input int start, input int n, input bit gaps);
        int k = 0;
        got_q.delete();
        out_ready = 1'b1;
        for (int c = 0; c < 3 * n + 8; c++) begin
            if (k < n && (!gaps || (c % 3) != 1)) begin
                in_valid = 1'b1;
                in_data = 38'(longint'(start + k) * 32768);
                k++;
            end else begin
                in_valid = 1'b0;
            end
            step();
            if (ov[1]) got_q.push_back(int'(od[1]));
        end
        in_valid = 1'b0;
    endtask

    // Reference: floor((x + 2^14) / 2^15), then clamp to 16-bit signed.
    function automatic void ref_scale(input longint x, output longint y, output bit s);
        longint q = x + 16384;
        if (q >= 0) y = q / 32768;
        else y = -((-q + 32767) / 32768);
        s = 1'b0;
        if (y > 32767) begin y = 32767; s = 1'b1; end
        if (y < -32768) begin y = -32768; s = 1'b1; end
    endfunction

    task automatic random_test();
        longint mq [2][$];
        int     cnt [2];
        bit     pv [2], ps [2], movf [2];
        longint pd [2];
        int     decim [2];
        logic [63:0] rw;
        longint v, y;
        bit     s, pop, drop;
        int     sz;
        decim[0] = 1;
        decim[1] = 4;
        for (int k = 0; k < 2; k++) begin
            cnt[k] = 0; pv[k] = 0; ps[k] = 0; movf[k] = 0; pd[k] = 0;
            mq[k].delete();
        end
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("rnd%0d_level", k), lv[k], mq[k].size());
                check($sformatf("rnd%0d_valid", k), ov[k], mq[k].size() != 0);
                if (mq[k].size() != 0) check($sformatf("rnd%0d_data", k), od[k], mq[k][0]);
                check($sformatf("rnd%0d_ovf", k), of[k], movf[k]);
                check($sformatf("rnd%0d_sat", k), sp[k], pv[k] && ps[k]);
            end
            in_valid = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0: begin rw = {$urandom, $urandom}; v = longint'($signed(rw[37:0])); end
                1: v = (longint'($urandom_range(0, 65535)) - 32768) * 32768
                       + longint'($urandom_range(0, 32767));
                2: v = longint'($urandom_range(0, 1 << 20)) - (1 << 19);
                default: v = (longint'($urandom_range(0, 200)) - 100) * 32768
                             + (($urandom_range(0, 1) != 0) ? 16384 : 16383);
            endcase
            in_data = v[37:0];
            if (((c / 250) % 2) == 1) out_ready = ($urandom_range(0, 7) == 0);
            else out_ready = ($urandom_range(0, 3) != 0);
            clr_ovf = ($urandom_range(0, 15) == 0);
            for (int k = 0; k < 2; k++) begin
                sz = mq[k].size();
                pop = (sz != 0) && out_ready;
                drop = 1'b0;
                if (pop) void'(mq[k].pop_front());
                if (pv[k]) begin
                    if (sz < 4 || pop) mq[k].push_back(pd[k]);
                    else drop = 1'b1;
                end
                if (drop) movf[k] = 1'b1;
                else if (clr_ovf) movf[k] = 1'b0;
                ref_scale(longint'(in_data), y, s);
                pv[k] = in_valid && ((cnt[k] % decim[k]) == 0);
                pd[k] = y;
                ps[k] = s;
                if (in_valid) cnt[k]++;
            end
            step();
        end
        in_valid = 1'b0;
        clr_ovf = 1'b0;
    endtask

    typedef struct {
        logic signed [37:0] din;
        logic signed [15:0] dout;
        logic               sat;
    } vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vt [11];
        vt[0]  = '{38'sd98304, 16'sd3, 1'b0};
        vt[1]  = '{38'sd16384, 16'sd1, 1'b0};
        vt[2]  = '{-38'sd16384, 16'sd0, 1'b0};
        vt[3]  = '{-38'sd49152, -16'sd1, 1'b0};
        vt[4]  = '{38'sd2147483648, 16'sd32767, 1'b1};
        vt[5]  = '{-38'sd2147483648, -16'sd32768, 1'b1};
        vt[6]  = '{38'sd1073709056, 16'sd32767, 1'b0};
        vt[7]  = '{38'sd1073725440, 16'sd32767, 1'b1};
        vt[8]  = '{-38'sd1073741824, -16'sd32768, 1'b0};
        vt[9]  = '{-38'sd1073758209, -16'sd32768, 1'b1};
        vt[10] = '{-38'sd16385, -16'sd1, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("reset%0d_valid", k), ov[k], 0);
            check($sformatf("reset%0d_data", k), od[k], 0);
            check($sformatf("reset%0d_sat", k), sp[k], 0);
            check($sformatf("reset%0d_ovf", k), of[k], 0);
            check($sformatf("reset%0d_level", k), lv[k], 0);
        end
        #2;
        rst_n = 1'b1;
        step();

        // Rounding and saturation, DECIM=1, ready high.
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            in_valid = 1'b1;
            in_data = vt[i].din;
            step();
            in_valid = 1'b0;
            check($sformatf("vec%0d_sat", i), sp[0], vt[i].sat);
            step();
            check($sformatf("vec%0d_valid", i), ov[0], 1);
            check($sformatf("vec%0d_data", i), od[0], vt[i].dout);
        end
        step();
        check("vec_drained_level", lv[0], 0);

        // Decimation by 4, continuous and with gaps.
        exp_q = '{0, 4, 8};
        do_reset();
        run_feed(0, 12, 1'b0);
        check_got("decim_cont");
        do_reset();
        run_feed(0, 12, 1'b1);
        check_got("decim_gaps");

        // Backpressure and overflow, DECIM=1.
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            in_valid = 1'b1;
            in_data = 38'(longint'(i) * 32768);
            step();
        end
        in_valid = 1'b0;
        repeat (2) step();
        check("bp_level_full", lv[0], 4);
        check("bp_ovf_set", of[0], 1);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("bp_valid_%0d", i), ov[0], 1);
            check($sformatf("bp_data_%0d", i), od[0], i);
            step();
        end
        check("bp_empty_valid", ov[0], 0);
        check("bp_empty_level", lv[0], 0);
        check("bp_ovf_sticky", of[0], 1);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        check("bp_ovf_cleared", of[0], 0);

        // Full FIFO with simultaneous push and pop.
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1;
            in_data = 38'(longint'(i) * 32768);
            step();
        end
        in_valid = 1'b0;
        repeat (2) step();
        check("pp_level_full", lv[0], 4);
        got_q.delete();
        in_valid = 1'b1;
        in_data = 38'(longint'(10) * 32768);
        step();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i < 2) in_data = 38'(longint'(11 + i) * 32768);
            else in_valid = 1'b0;
            if (ov[0]) got_q.push_back(int'(od[0]));
            step();
            check($sformatf("pp_level_%0d", i), lv[0], 4);
        end
        for (int i = 0; i < 6; i++) begin
            if (ov[0]) got_q.push_back(int'(od[0]));
            step();
        end
        check("pp_ovf_clear", of[0], 0);
        exp_q = '{1, 2, 3, 4, 10, 11, 12};
        check_got("pp_order");

        // Reset mid-stream with data buffered and the pipeline busy.
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            in_valid = 1'b1;
            in_data = 38'(longint'(i) * 32768);
            step();
        end
        in_valid = 1'b0;
        repeat (2) step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 38'(longint'(7) * 32768);
        step();
        in_data = 38'(longint'(8) * 32768);
        check("mid_pre_level", lv[0], 3);
        check("mid_pre_ovf", of[0], 1);
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("mid%0d_valid", k), ov[k], 0);
            check($sformatf("mid%0d_level", k), lv[k], 0);
            check($sformatf("mid%0d_ovf", k), of[k], 0);
            check($sformatf("mid%0d_sat", k), sp[k], 0);
        end
        in_valid = 1'b0;
        #1;
        rst_n = 1'b1;
        step();
        run_feed(1, 8, 1'b0);
        exp_q = '{1, 5};
        check_got("mid_restart");

        // Randomized comparison against the reference model.
        do_reset();
        random_test();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
